div_unit: RTL



---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the iterative divider
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    localparam int DIV_ITER = 32;

    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_SMIN     = 32'h8000_0000;

    // op[0]==0 marks the signed variants (DIV, REM)
    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            borrow;

    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dvs};
    // A trial that does not fit the remainder is only possible with a zero
    // divisor, whose result is overridden later; treat it like a borrow.
    assign borrow = diff[XLEN+1] | diff[XLEN];

    assign rem_next = borrow ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative DIV/DIVU/REM/REMU unit, early-out via DIV_EARLY_OUT_EN
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(DIV_ITER);

    div_state_e      state_q, state_d;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, dvs_q;
    logic            neg_q, neg_r;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] rem_step, quo_step;
    logic [XLEN-1:0] abs_a, abs_b, fix_val, sel_val;
    logic            sgn, sel_neg, early_out, busy_d;

    assign sgn   = op_is_signed(op);
    assign abs_a = (sgn && a[XLEN-1]) ? -a : a;
    assign abs_b = (sgn && b[XLEN-1]) ? -b : b;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (b == '0) || (sgn && a == DIV_SMIN && b == DIV_ALL_ONES);
`else
    assign early_out = 1'b0;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = early_out ? ST_FIX : ST_CALC;
            ST_CALC: if (count_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_val = op_q[1] ? rem_q : quo_q;
        sel_neg = op_is_signed(op_q) && (op_q[1] ? neg_r : neg_q);
        fix_val = sel_neg ? -sel_val : sel_val;
        if (b_q == '0)
            fix_val = op_q[1] ? a_q : DIV_ALL_ONES;
        else if (op_is_signed(op_q) && a_q == DIV_SMIN && b_q == DIV_ALL_ONES)
            fix_val = op_q[1] ? '0 : DIV_SMIN;
        // busy stays up through the done cycle and only then follows start
        busy_d = (state_d != ST_IDLE) || (state_q == ST_FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= busy_d;
            done <= (state_q == ST_FIX);
            if (state_q == ST_FIX) result <= fix_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            count_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            rem_q   <= '0;
            quo_q   <= abs_a;
            dvs_q   <= abs_b;
            neg_q   <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r   <= sgn && a[XLEN-1];
            count_q <= CW'(DIV_ITER - 1);
        end else if (state_q == ST_CALC) begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= count_q - 1'b1;
        end
    end

endmodule
